// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage in front of the load/store unit.
// Buffers one instruction from EX, issues at most one LSU load or store,
// and hands the result to WB. Misaligned accesses never reach the LSU;
// they are reported on wb_misalign instead.
module mem_stage #(
    parameter int XLEN = 64,
    parameter int AW   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [31:0]     ex_pc,
    input  logic [4:0]      ex_rd,
    input  logic            ex_rd_wen,
    input  logic            ex_is_load,
    input  logic            ex_is_store,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_store_data,
    output logic [AW-1:0]   lsu_addr,
    output logic [2:0]      funct3,
    output logic            lsu_r_ready,
    input  logic [XLEN-1:0] lsu_r_data,
    input  logic            lsu_r_valid,
    output logic            lsu_w_valid,
    output logic [XLEN-1:0] lsu_w_data,
    input  logic            lsu_w_ready,
    input  logic            lsu_busy,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [31:0]     wb_pc,
    output logic [4:0]      wb_rd,
    output logic            wb_rd_wen,
    output logic [XLEN-1:0] wb_rd_data,
    output logic            wb_misalign
);

    typedef enum logic [1:0] {EMPTY, LOAD, STORE, FULL} state_t;

    state_t          state;
    logic [31:0]     pc_q;
    logic [4:0]      rd_q;
    logic            rd_wen_q;
    logic [2:0]      funct3_q;
    logic [AW-1:0]   addr_q;
    logic [XLEN-1:0] sd_q;
    logic [XLEN-1:0] rd_data_q;
    logic            mis_q;
    logic            issued;  // request seen by the LSU, must run to completion
    logic            killed;  // flushed after issue: drop the response

    logic accept;
    logic addr_mis;
    logic ex_mis;

    // Alignment check on the effective address, by access width
    always_comb begin
        addr_mis = 1'b0;
        case (ex_funct3[1:0])
            2'b01:   addr_mis = ex_alu_result[0];
            2'b10:   addr_mis = |ex_alu_result[1:0];
            2'b11:   addr_mis = |ex_alu_result[2:0];
            default: addr_mis = 1'b0;
        endcase
    end

    assign ex_mis   = (ex_is_load | ex_is_store) & addr_mis;
    assign ex_ready = ~flush & ((state == EMPTY) | ((state == FULL) & wb_ready));
    assign accept   = ex_valid & ex_ready;

    // Request drops in the response cycle so the device sees exactly one access.
    // An un-issued request is suppressed while flush is high so a flush never
    // starts a new access.
    assign lsu_r_ready = (state == LOAD)  & (issued | (~lsu_busy & ~flush)) & ~lsu_r_valid;
    assign lsu_w_valid = (state == STORE) & (issued | (~lsu_busy & ~flush)) & ~lsu_w_ready;

    assign lsu_addr    = addr_q;
    assign funct3      = funct3_q;
    assign lsu_w_data  = sd_q;
    assign wb_valid    = (state == FULL);
    assign wb_pc       = pc_q;
    assign wb_rd       = rd_q;
    assign wb_rd_wen   = rd_wen_q;
    assign wb_rd_data  = rd_data_q;
    assign wb_misalign = mis_q;

    // Stage state machine and instruction buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            pc_q      <= '0;
            rd_q      <= '0;
            rd_wen_q  <= 1'b0;
            funct3_q  <= '0;
            addr_q    <= '0;
            sd_q      <= '0;
            rd_data_q <= '0;
            mis_q     <= 1'b0;
            issued    <= 1'b0;
            killed    <= 1'b0;
        end else begin
            case (state)
                FULL: begin
                    if (flush | wb_ready) state <= EMPTY;
                end
                LOAD: begin
                    if (lsu_r_valid) begin
                        issued <= 1'b0;
                        killed <= 1'b0;
                        if (killed | flush) begin
                            state <= EMPTY;
                        end else begin
                            rd_data_q <= lsu_r_data;
                            state     <= FULL;
                        end
                    end else if (flush & ~issued) begin
                        state <= EMPTY;
                    end else begin
                        if (flush)       killed <= 1'b1;
                        if (lsu_r_ready) issued <= 1'b1;
                    end
                end
                STORE: begin
                    if (lsu_w_ready) begin
                        issued <= 1'b0;
                        killed <= 1'b0;
                        state  <= (killed | flush) ? EMPTY : FULL;
                    end else if (flush & ~issued) begin
                        state <= EMPTY;
                    end else begin
                        if (flush)       killed <= 1'b1;
                        if (lsu_w_valid) issued <= 1'b1;
                    end
                end
                default: ;
            endcase

            // A new instruction overrides the drain decision above (back-to-back)
            if (accept) begin
                pc_q      <= ex_pc;
                rd_q      <= ex_rd;
                rd_wen_q  <= ex_rd_wen & ~ex_is_store & ~ex_mis;
                funct3_q  <= ex_funct3;
                addr_q    <= ex_alu_result[AW-1:0];
                sd_q      <= ex_store_data;
                rd_data_q <= ex_alu_result;
                mis_q     <= ex_mis;
                issued    <= 1'b0;
                killed    <= 1'b0;
                if (ex_mis)           state <= FULL;
                else if (ex_is_load)  state <= LOAD;
                else if (ex_is_store) state <= STORE;
                else                  state <= FULL;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed sequence for mem_stage with a WB-side scoreboard.
`timescale 1ns/1ps
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst, flush, ex_valid, ex_ready;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rd;
    logic        ex_rd_wen, ex_is_load, ex_is_store;
    logic [2:0]  ex_funct3;
    logic [63:0] ex_alu_result, ex_store_data;
    logic [31:0] lsu_addr;
    logic [2:0]  funct3;
    logic        lsu_r_ready, lsu_r_valid, lsu_w_valid, lsu_w_ready, lsu_busy;
    logic [63:0] lsu_r_data, lsu_w_data;
    logic        wb_valid, wb_ready, wb_rd_wen, wb_misalign;
    logic [31:0] wb_pc;
    logic [4:0]  wb_rd;
    logic [63:0] wb_rd_data;

    mem_stage #(.XLEN(64), .AW(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_rd(ex_rd),
        .ex_rd_wen(ex_rd_wen), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .lsu_addr(lsu_addr), .funct3(funct3), .lsu_r_ready(lsu_r_ready),
        .lsu_r_data(lsu_r_data), .lsu_r_valid(lsu_r_valid), .lsu_w_valid(lsu_w_valid),
        .lsu_w_data(lsu_w_data), .lsu_w_ready(lsu_w_ready), .lsu_busy(lsu_busy),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc), .wb_rd(wb_rd),
        .wb_rd_wen(wb_rd_wen), .wb_rd_data(wb_rd_data), .wb_misalign(wb_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        wen;
        logic        mis;
        logic        chk_data;
        logic [63:0] data;
    } exp_t;

    exp_t q[$];
    exp_t got;
    int   passed = 0;
    int   total  = 0;
    int   fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an instruction on the EX side; optionally record its WB result
    task automatic drive_ex(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                            input logic ld, input logic st, input logic [2:0] f3,
                            input logic [63:0] alu, input logic [63:0] sd,
                            input logic [63:0] ld_data, input bit push);
        exp_t e;
        logic mis;
        ex_pc = pc; ex_rd = rd; ex_rd_wen = wen; ex_is_load = ld; ex_is_store = st;
        ex_funct3 = f3; ex_alu_result = alu; ex_store_data = sd; ex_valid = 1'b1;
        mis = (ld | st) && ((f3[1:0] == 2'b01 && alu[0] != 1'b0) ||
                            (f3[1:0] == 2'b10 && alu[1:0] != 2'b00) ||
                            (f3[1:0] == 2'b11 && alu[2:0] != 3'b000));
        if (push) begin
            e.pc = pc; e.rd = rd; e.mis = mis;
            e.wen = wen && !st && !mis;
            e.chk_data = !mis && !st;
            e.data = ld ? ld_data : alu;
            q.push_back(e);
        end
    endtask

    // Drive and wait (bounded) for the accepting edge; returns at edge+1
    task automatic send(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                        input logic ld, input logic st, input logic [2:0] f3,
                        input logic [63:0] alu, input logic [63:0] sd,
                        input logic [63:0] ld_data, input bit push);
        bit ok = 0;
        drive_ex(pc, rd, wen, ld, st, f3, alu, sd, ld_data, push);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ex_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        ex_valid = 1'b0;
        if (!ok) chk("accept_timeout", 64'(ok), 64'd1);
    endtask

    // WB scoreboard: every handshake must match the oldest expected result
    always @(negedge clk) begin
        if (!rst && wb_valid && wb_ready) begin
            if (q.size() == 0) begin
                chk("wb_unexpected", 64'd1, 64'd0);
            end else begin
                got = q.pop_front();
                chk("wb_pc", 64'(wb_pc), 64'(got.pc));
                chk("wb_rd", 64'(wb_rd), 64'(got.rd));
                chk("wb_rd_wen", 64'(wb_rd_wen), 64'(got.wen));
                chk("wb_misalign", 64'(wb_misalign), 64'(got.mis));
                if (got.chk_data) chk("wb_rd_data", wb_rd_data, got.data);
            end
        end
    end

    initial begin
        rst = 1; flush = 0; ex_valid = 0; ex_pc = 0; ex_rd = 0; ex_rd_wen = 0;
        ex_is_load = 0; ex_is_store = 0; ex_funct3 = 0; ex_alu_result = 0; ex_store_data = 0;
        lsu_r_data = 0; lsu_r_valid = 0; lsu_w_ready = 0; lsu_busy = 0; wb_ready = 0;

        // Reset values
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_lsu_r_ready", 64'(lsu_r_ready), 64'd0);
        chk("rst_lsu_w_valid", 64'(lsu_w_valid), 64'd0);
        chk("rst_wb_misalign", 64'(wb_misalign), 64'd0);
        chk("rst_ex_ready", 64'(ex_ready), 64'd1);
        rst = 0; wb_ready = 1;
        @(posedge clk); #1;

        // ADD, one-cycle latency
        send(32'h100, 5'd1, 1, 0, 0, 3'b000, 64'h1234, 0, 0, 1);
        @(negedge clk);
        chk("add_latency_wb_valid", 64'(wb_valid), 64'd1);
        chk("add_data", wb_rd_data, 64'h1234);
        @(posedge clk); #1;

        // Four back-to-back ALU ops at one per cycle
        for (int i = 0; i < 4; i++) begin
            drive_ex(32'h104 + 32'(4 * i), 5'(2 + i), 1, 0, 0, 3'b000,
                     64'h1000 + 64'(i), 0, 0, 1);
            @(negedge clk);
            chk("b2b_ex_ready", 64'(ex_ready), 64'd1);
            @(posedge clk); #1;
        end
        ex_valid = 0;
        @(posedge clk); #1;

        // LD with the cache busy for 3 cycles, response 5 cycles after issue
        lsu_busy = 1;
        send(32'h200, 5'd5, 1, 1, 0, 3'b011, 64'h80001000, 0, 64'hDEADBEEF_CAFEF00D, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ld_busy_no_req", 64'(lsu_r_ready), 64'd0);
            @(posedge clk); #1;
        end
        lsu_busy = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) lsu_busy = 1;
            @(negedge clk);
            chk("ld_req_held", 64'(lsu_r_ready), 64'd1);
            chk("ld_addr", 64'(lsu_addr), 64'h80001000);
            @(posedge clk); #1;
        end
        lsu_r_valid = 1; lsu_r_data = 64'hDEADBEEF_CAFEF00D;
        @(negedge clk);
        chk("ld_req_low_in_resp", 64'(lsu_r_ready), 64'd0);
        @(posedge clk); #1;
        lsu_r_valid = 0; lsu_busy = 0;
        @(negedge clk);
        chk("ld_wb_valid", 64'(wb_valid), 64'd1);
        @(posedge clk); #1;

        // SW with a stray read pulse that must be ignored
        send(32'h300, 5'd7, 1, 0, 1, 3'b010, 64'hA00003F8, 64'h55, 0, 1);
        for (int i = 0; i < 3; i++) begin
            lsu_r_valid = (i == 1);
            @(negedge clk);
            chk("sw_w_valid", 64'(lsu_w_valid), 64'd1);
            chk("sw_addr", 64'(lsu_addr), 64'hA00003F8);
            chk("sw_funct3", 64'(funct3), 64'd2);
            chk("sw_w_data", lsu_w_data, 64'h55);
            @(posedge clk); #1;
        end
        lsu_r_valid = 0; lsu_w_ready = 1;
        @(negedge clk);
        chk("sw_w_valid_low_in_resp", 64'(lsu_w_valid), 64'd0);
        @(posedge clk); #1;
        lsu_w_ready = 0;
        @(negedge clk);
        chk("sw_wb_valid", 64'(wb_valid), 64'd1);
        @(posedge clk); #1;

        // Misaligned LW and SH never reach the LSU
        send(32'h400, 5'd8, 1, 1, 0, 3'b010, 64'h80000002, 0, 0, 1);
        @(negedge clk);
        chk("lw_mis_flag", 64'(wb_misalign), 64'd1);
        chk("lw_mis_no_req", 64'(lsu_r_ready), 64'd0);
        @(posedge clk); #1;
        send(32'h404, 5'd9, 0, 0, 1, 3'b001, 64'h80000001, 64'h77, 0, 1);
        @(negedge clk);
        chk("sh_mis_flag", 64'(wb_misalign), 64'd1);
        chk("sh_mis_no_req", 64'(lsu_w_valid), 64'd0);
        @(posedge clk); #1;

        // WB stall for 10 cycles, then release with a new LD in the same cycle
        wb_ready = 0;
        send(32'h500, 5'd10, 1, 0, 0, 3'b000, 64'hABC, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_ex_ready", 64'(ex_ready), 64'd0);
            chk("stall_wb_valid", 64'(wb_valid), 64'd1);
            chk("stall_wb_data", wb_rd_data, 64'hABC);
            @(posedge clk); #1;
        end
        wb_ready = 1;
        drive_ex(32'h504, 5'd11, 1, 1, 0, 3'b011, 64'h80002000, 0, 64'h77, 1);
        @(negedge clk);
        chk("release_ex_ready", 64'(ex_ready), 64'd1);
        @(posedge clk); #1;
        ex_valid = 0;
        @(negedge clk);
        chk("release_ld_issue", 64'(lsu_r_ready), 64'd1);
        @(posedge clk); #1;
        lsu_r_valid = 1; lsu_r_data = 64'h77;
        @(posedge clk); #1;
        lsu_r_valid = 0;
        @(negedge clk);
        chk("release_ld_wb_valid", 64'(wb_valid), 64'd1);
        @(posedge clk); #1;

        // Flush an un-issued load
        lsu_busy = 1;
        send(32'h600, 5'd12, 1, 1, 0, 3'b011, 64'h80003000, 0, 0, 0);
        flush = 1;
        @(negedge clk);
        chk("flush_unissued_no_req", 64'(lsu_r_ready), 64'd0);
        chk("flush_ex_ready", 64'(ex_ready), 64'd0);
        @(posedge clk); #1;
        flush = 0;
        @(negedge clk);
        chk("flush_unissued_empty", 64'(ex_ready), 64'd1);
        chk("flush_unissued_wb_valid", 64'(wb_valid), 64'd0);
        @(posedge clk); #1;
        lsu_busy = 0;

        // Flush after issue: request held to completion, result dropped
        send(32'h700, 5'd13, 1, 1, 0, 3'b011, 64'h80004000, 0, 0, 0);
        @(posedge clk); #1;
        flush = 1;
        @(negedge clk);
        chk("flush_issued_req", 64'(lsu_r_ready), 64'd1);
        chk("flush_issued_ex_ready", 64'(ex_ready), 64'd0);
        @(posedge clk); #1;
        flush = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("flush_issued_req_held", 64'(lsu_r_ready), 64'd1);
            chk("flush_issued_ex_ready_low", 64'(ex_ready), 64'd0);
            @(posedge clk); #1;
        end
        lsu_r_valid = 1; lsu_r_data = 64'hBAD0BAD0;
        @(negedge clk);
        chk("flush_issued_resp_req_low", 64'(lsu_r_ready), 64'd0);
        @(posedge clk); #1;
        lsu_r_valid = 0;
        @(negedge clk);
        chk("flush_issued_no_wb", 64'(wb_valid), 64'd0);
        chk("flush_issued_empty", 64'(ex_ready), 64'd1);
        @(posedge clk); #1;

        // Reset in the middle of an issued load
        send(32'h800, 5'd14, 1, 1, 0, 3'b011, 64'h80005000, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_wb_valid", 64'(wb_valid), 64'd0);
        chk("midrst_lsu_r_ready", 64'(lsu_r_ready), 64'd0);
        chk("midrst_lsu_w_valid", 64'(lsu_w_valid), 64'd0);
        chk("midrst_wb_misalign", 64'(wb_misalign), 64'd0);
        chk("midrst_ex_ready", 64'(ex_ready), 64'd1);
        rst = 0;
        @(posedge clk); #1;

        // Stage still works after reset
        send(32'h900, 5'd15, 1, 0, 0, 3'b000, 64'h42, 0, 0, 1);

        for (int i = 0; i < 20; i++) begin
            if (q.size() == 0) break;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
